// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared constants and helpers for the seven-segment display driver.
//   SEG_HEX   : 16-entry hex-to-segment table, active-low, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK : all segments off (active-low encoding)
//   seg_hex() : nibble -> active-low segment pattern
// -----------------------------------------------------------------------------
package io_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b0100111,  // c
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  function automatic logic [6:0] seg_hex(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// -----------------------------------------------------------------------------
// seg_tick_gen
// Free-running prescaler that produces a one-cycle refresh tick every DIV
// clocks, so the scanner runs entirely in the system clock domain.
//   CLK   in  system clock
//   RST_N in  asynchronous active-low reset
//   tick  out high for one cycle when the prescaler is at DIV-1
// -----------------------------------------------------------------------------
module seg_tick_gen #(
  parameter int DIV = 10
) (
  input  logic CLK,
  input  logic RST_N,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] psc_q;
  logic [CW-1:0] psc_d;

  // Tick is decoded straight from the prescaler register, so it is aligned
  // with the cycle in which the count sits at its last value.
  assign tick = (psc_q == LAST);

  always_comb begin
    psc_d = psc_q + CW'(1);
    if (tick) begin
      psc_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

endmodule

// File: rtl/seg_display_scan.sv
// -----------------------------------------------------------------------------
// seg_display_scan
// Multiplexed seven-segment display driver with paging, leading-zero blanking,
// decimal points, anti-ghosting guard interval and selectable polarity.
//   CLK        in  system clock
//   RST_N      in  asynchronous active-low reset (blanks outputs immediately)
//   data       in  word to display, captured only while load is high
//   dp_mask    in  decimal-point enables, bit i = digit i (captured with data)
//   load       in  capture strobe for data and dp_mask
//   page_sel   in  which 4*NUM_DIGITS-bit slice to show, sampled at frame end
//   lz_blank   in  leading-zero suppression enable
//   blank_all  in  force all anodes inactive
//   seg        out segments {g,f,e,d,c,b,a}
//   dp         out decimal point
//   an         out digit anodes
//   digit_idx  out current scan index
//   frame_done out one-cycle pulse on the tick that wraps the scan
// -----------------------------------------------------------------------------
module seg_display_scan
  import io_pkg::*;
#(
  parameter int  NUM_DIGITS = 4,
  parameter int  DATA_W     = 32,
  parameter int  CLK_HZ     = 100_000_000,
  parameter int  REFRESH_HZ = 1000,
  parameter int  GUARD_CYC  = 2,
  parameter bit  ACTIVE_LOW = 1'b1,
  localparam int PAGES      = DATA_W / (4 * NUM_DIGITS),
  localparam int PW         = (PAGES > 1) ? $clog2(PAGES) : 1,
  localparam int DW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DATA_W-1:0]     data,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  load,
  input  logic [PW-1:0]         page_sel,
  input  logic                  lz_blank,
  input  logic                  blank_all,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic [DW-1:0]         digit_idx,
  output logic                  frame_done
);

  // DIV must be at least GUARD_CYC+2 so every digit gets some on-time.
  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int GW  = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;

  localparam logic [GW-1:0]         GUARD_LOAD = GW'(GUARD_CYC);
  localparam logic [DW-1:0]         LAST_DIGIT = DW'(NUM_DIGITS - 1);
  // Inactive levels as they appear on the pins for the chosen polarity.
  localparam logic [6:0]            SEG_OFF    = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = ACTIVE_LOW ? '1 : '0;
  localparam logic                  DP_OFF     = ACTIVE_LOW;

  logic tick;

  seg_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .tick  (tick)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DW-1:0]         digit_idx_q, digit_idx_d;
  logic [GW-1:0]         guard_q,     guard_d;
  logic [PW-1:0]         page_q,      page_d;
  logic                  frame_q,     frame_d;
  logic [DATA_W-1:0]     shadow_q,    shadow_d;
  logic [NUM_DIGITS-1:0] dp_shadow_q, dp_shadow_d;
  logic [6:0]            seg_q,       seg_d;
  logic                  dp_q,        dp_d;
  logic [NUM_DIGITS-1:0] an_q,        an_d;

  logic at_last;
  assign at_last = (digit_idx_q == LAST_DIGIT);

  // ---------------------------------------------------------------------------
  // Scan, guard and page control
  // ---------------------------------------------------------------------------
  always_comb begin
    digit_idx_d = digit_idx_q;
    guard_d     = guard_q;
    page_d      = page_q;
    frame_d     = 1'b0;
    if (tick) begin
      digit_idx_d = at_last ? '0 : digit_idx_q + DW'(1);
      guard_d     = GUARD_LOAD;
      if (at_last) begin
        frame_d = 1'b1;
        // Out-of-range page requests fall back to the least significant page.
        page_d  = (32'(page_sel) < PAGES) ? page_sel : '0;
      end
    end else if (guard_q != '0) begin
      guard_d = guard_q - GW'(1);
    end
  end

  // Capture is independent of the scan; a load on a tick edge just works.
  always_comb begin
    shadow_d    = shadow_q;
    dp_shadow_d = dp_shadow_q;
    if (load) begin
      shadow_d    = data;
      dp_shadow_d = dp_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Nibble extraction for the page currently on display
  // ---------------------------------------------------------------------------
  logic [3:0] page_nib [PAGES][NUM_DIGITS];
  logic [3:0] cur_nib  [NUM_DIGITS];

  generate
    for (genvar gp = 0; gp < PAGES; gp++) begin : g_page
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
        assign page_nib[gp][gi] = shadow_q[(gp * NUM_DIGITS + gi) * 4 +: 4];
      end
    end
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_cur
      assign cur_nib[gi] = page_nib[page_q][gi];
    end
  endgenerate

  // A digit is a leading zero when it and every more significant digit on the
  // page are zero. Digit 0 is never suppressed so a zero value reads "0".
  logic [NUM_DIGITS-1:0] suppress;
  logic                  all_zero;

  always_comb begin
    suppress = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero    = all_zero && (cur_nib[i] == 4'h0);
      suppress[i] = lz_blank && all_zero;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register inputs (built active-low, flipped for active-high boards)
  // ---------------------------------------------------------------------------
  logic [6:0]            seg_raw;
  logic                  dp_raw;
  logic [NUM_DIGITS-1:0] an_raw;

  always_comb begin
    seg_raw = seg_hex(cur_nib[digit_idx_q]);
    if (suppress[digit_idx_q]) begin
      seg_raw = SEG_BLANK;
    end
    dp_raw = ~dp_shadow_q[digit_idx_q];
    // Segments already carry the new digit during the guard interval; only
    // the anodes are held off so the previous digit does not ghost.
    an_raw = ~(NUM_DIGITS'(1) << digit_idx_q);
    if ((guard_q != '0) || blank_all) begin
      an_raw = '1;
    end
    seg_d = ACTIVE_LOW ? seg_raw : ~seg_raw;
    dp_d  = ACTIVE_LOW ? dp_raw  : ~dp_raw;
    an_d  = ACTIVE_LOW ? an_raw  : ~an_raw;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      digit_idx_q <= '0;
      guard_q     <= GUARD_LOAD;
      page_q      <= '0;
      frame_q     <= 1'b0;
      shadow_q    <= '0;
      dp_shadow_q <= '0;
      seg_q       <= SEG_OFF;
      dp_q        <= DP_OFF;
      an_q        <= AN_OFF;
    end else begin
      digit_idx_q <= digit_idx_d;
      guard_q     <= guard_d;
      page_q      <= page_d;
      frame_q     <= frame_d;
      shadow_q    <= shadow_d;
      dp_shadow_q <= dp_shadow_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_q;

endmodule

// File: doc/seg_display_scan.md
Name: seg_display_scan

Overview:
- Parametrised multiplexed seven-segment display driver; successor to the fixed 4-digit scanner in the board I/O controller.
- Generates its own refresh tick from the system clock, so no separate slow clock domain is needed.
- Captures the displayed value only on an explicit load strobe.
- Adds paging of wide words, leading-zero blanking, decimal points, anti-ghosting guard cycles and selectable output polarity.

Parameters:
- NUM_DIGITS, 4, number of physical digits scanned.
- DATA_W, 32, width of displayed word. Must be a multiple of 4*NUM_DIGITS.
- CLK_HZ, 100_000_000, CLK frequency.
- REFRESH_HZ, 1000, per-digit step rate. DIV = CLK_HZ/REFRESH_HZ. Requires DIV >= GUARD_CYC+2.
- GUARD_CYC, 2, cycles all anodes are held off after each digit change.
- ACTIVE_LOW, 1, 1 = seg/an/dp asserted low (Basys-style); 0 = active high.

Derived values:
- PAGES = DATA_W/(4*NUM_DIGITS).
- PW = max(1, $clog2(PAGES)).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- data  in  DATA_W  value to display.
- dp_mask  in  NUM_DIGITS  decimal-point enables, bit i = digit i.
- load  in  1  capture strobe for data and dp_mask.
- page_sel  in  PW  which 4*NUM_DIGITS-bit slice to show; page 0 = LSBs.
- lz_blank  in  1  enable leading-zero suppression.
- blank_all  in  1  force all anodes inactive.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.
- an  out  NUM_DIGITS  digit anodes.
- digit_idx  out  $clog2(NUM_DIGITS)  current scan index.
- frame_done  out  1  one-cycle pulse at end of each full scan.

Behaviour:
- Clock and reset: one clock CLK; reset RST_N is asynchronous, active-low. All state and outputs are registered.
- Reset values:
  - prescaler = 0, digit_idx = 0, guard counter = GUARD_CYC.
  - shadow data/dp = 0, page_q = 0.
  - an = all inactive, seg = blank (all inactive), dp = inactive, frame_done = 0.
  - Reset asserted mid-scan blanks outputs immediately (asynchronously).
- Prescaler:
  - Counts 0..DIV-1, then wraps.
  - tick = (prescaler == DIV-1).
- Scan:
  - On tick, digit_idx increments and wraps from NUM_DIGITS-1 to 0.
  - On the tick that wraps, frame_done = 1 for exactly that cycle.
  - On the same tick, page_q <= page_sel. Page changes apply only at frame boundaries, never mid-frame. page_sel >= PAGES maps to page 0.
- Guard:
  - On every tick, the guard counter reloads to GUARD_CYC.
  - While the counter is nonzero, an is all inactive and the counter decrements. seg/dp already carry the new digit's pattern during this time.
  - GUARD_CYC = 0 means no off interval.
- Capture:
  - load = 1 at an edge copies data and dp_mask into the shadow registers.
  - Display changes take effect on the next output register update (1-cycle latency).
  - load simultaneous with tick or frame boundary: both take effect; there is no priority conflict.
  - When load = 0, changes on data are ignored.
- Output register update, every cycle:
  - nibble = shadow[(page_q*NUM_DIGITS + digit_idx)*4 +: 4].
  - seg = hex decode of nibble, or blank if the digit is suppressed.
  - dp = dp_shadow[digit_idx].
  - an = one-hot of digit_idx unless guard is active or blank_all = 1.
- Leading-zero suppression: digit i (i > 0) is suppressed when lz_blank = 1 and every nibble at positions i..NUM_DIGITS-1 of the current page is 0. Digit 0 is never suppressed, so zero displays as "0".
- blank_all: forces an inactive on the next edge. Scan counters keep running.
- Hex decode, active-low patterns:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - c=0100111, d=0100001, E=0000110, F=0001110
- Polarity: ACTIVE_LOW = 0 inverts seg, dp and an at the output register.

Decomposition:
- Package io_pkg holds:
  - SEG_HEX lookup (16 x 7-bit constant array, active-low).
  - SEG_BLANK = 7'h7F.
  - function seg_hex(nibble).
- Sub-module seg_tick_gen(CLK, RST_N -> tick), parametrised by DIV.
- Decode, suppression and scan logic stay in seg_display_scan.

Test Plan (CLK_HZ=1000, REFRESH_HZ=100 so DIV=10; GUARD_CYC=2; NUM_DIGITS=4; DATA_W=32):
1. Reset: drop RST_N during scan at digit 2 -> an=1111, seg=1111111, dp=1 within the same cycle. After release, digit_idx=0 and the first tick occurs at cycle 10.
2. Basic scan: load 32'h0000_1234, lz_blank=0, page 0 -> per step, an is 1111 for 2 cycles, then 1110/1101/1011/0111 for 8 cycles each.
   - seg sequence: 0011001, 0110000, 0100100, 1111001.
   - frame_done pulses every 40 cycles.
3. Leading zero: load 32'h0000_0050, lz_blank=1 -> digit0 = 1000000, digit1 = 0010010, digits 2/3 seg = 1111111. Then load 0 -> only digit0 shows 1000000.
4. Paging: load 32'hDEAD_BEEF; set page_sel=1 mid-frame -> remainder of frame still shows "BEEF"; the next frame shows "DEAD" (digit0 = 0100001, digit1 = 0001000).
5. Capture/dp: change data without load -> seg unchanged. Pulse load with data=32'h9, dp_mask=4'b0001 while digit 0 is active -> next cycle seg=0010000, dp=0.
6. Polarity/blank: ACTIVE_LOW=0 -> digit0 an=0001, seg for "8" = 1111111. Assert blank_all -> an=0000 next cycle while digit_idx keeps advancing.
